// File: rtl/uart_rx_sampler.sv
// 8N1 serial receiver with centre-of-bit sampling, valid/ready byte delivery,
// and framing/overrun error pulses. CLK_DIVIDER clocks per bit.
module uart_rx_sampler #(
  parameter int CLK_DIVIDER = 200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CNT_W = $clog2(CLK_DIVIDER);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIVIDER / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIVIDER - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic             rx_meta_p0;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             vld_p1;
  logic             tick;

  assign tick = (cnt == '0);

  // Stage 0: two-flop synchroniser, idle-high so reset looks like an idle line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= i_uart_rx;
      rx_s       <= rx_meta_p0;
    end
  end

  // Stage 1: frame FSM; counter only runs while timing a bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      vld_p1      <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
      if (state != IDLE && state != BREAK && !tick) begin
        cnt <= cnt - 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              cnt    <= CNT_HALF;
              o_busy <= 1'b1;
            end
          end
          START: begin
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= CNT_FULL;
              idx   <= '0;
            end
          end
          DATA: begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= CNT_FULL;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end
          STOP: begin
            if (rx_s) begin
              vld_p1 <= 1'b1;
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end
          BREAK: begin
            // a line held low must return high before a new start is accepted
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage 2: output holding register with valid/ready handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (vld_p1) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
